// File: rtl/scan_index_sequencer_if.sv
// Control/observation bundle for scan_index_sequencer: run controls in, decoder select and strobes out.
// With SCAN_WRAP_CNT_EN defined the bundle also carries the saturating wrap counter.
interface scan_index_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               en;
    logic               mode;
    logic               dir;
    logic [DWELL_W-1:0] dwell;
    logic               step;
    logic               load;
    logic [2:0]         load_idx;
    logic               x;
    logic               y;
    logic               z;
    logic               tick;
    logic               wrap;
`ifdef SCAN_WRAP_CNT_EN
    logic [7:0]         wrap_cnt;
`endif

    modport master (
        output en, mode, dir, dwell, step, load, load_idx,
        input  x, y, z, tick, wrap
`ifdef SCAN_WRAP_CNT_EN
        , input wrap_cnt
`endif
    );

    modport slave (
        input  en, mode, dir, dwell, step, load, load_idx,
        output x, y, z, tick, wrap
`ifdef SCAN_WRAP_CNT_EN
        , output wrap_cnt
`endif
    );
endinterface

// File: rtl/scan_index_sequencer.sv
// Steps the 3-bit decoder select {x,y,z} through 0..7 (linear up/down or ping-pong) at a dwell rate.
// Optional SCAN_WRAP_CNT_EN adds a saturating count of wrap/turnaround events on wrap_cnt.
module scan_index_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    scan_index_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

    state_t             state, state_nxt;
    logic [2:0]         idx, idx_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic               pp_dir, pp_dir_nxt;   // ping-pong travel: 0 = up, 1 = down
    logic               step_q;
    logic               step_rise;
    logic               advance;
    logic               wrap_nxt;
    logic               tick_r, wrap_r;

    assign step_rise = bus.step & ~step_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= '0;
            pp_dir <= 1'b0;
            step_q <= 1'b0;
            tick_r <= 1'b0;
            wrap_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            cnt    <= cnt_nxt;
            pp_dir <= pp_dir_nxt;
            step_q <= bus.step;
            tick_r <= advance;
            wrap_r <= wrap_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = IDLE;
        if (bus.load)
            state_nxt = IDLE;
        else if (bus.en)
            state_nxt = RUN;
        else if (state == IDLE && step_rise)
            state_nxt = STEP;
    end

    always_comb begin
        advance = 1'b0;
        if (!bus.load) begin
            if (bus.en)
                advance = (cnt >= bus.dwell);   // >= so a lowered dwell expires at once
            else
                advance = (state_nxt == STEP);
        end

        cnt_nxt = '0;
        if (!bus.load && bus.en && !advance)
            cnt_nxt = cnt + 1'b1;

        pp_dir_nxt = pp_dir;
        if (!bus.load && !bus.mode)
            pp_dir_nxt = bus.dir;

        idx_nxt  = idx;
        wrap_nxt = 1'b0;
        if (bus.load) begin
            idx_nxt = bus.load_idx;
        end else if (advance) begin
            if (!bus.mode) begin
                if (bus.dir) begin
                    idx_nxt  = idx - 3'd1;
                    wrap_nxt = (idx == 3'd0);
                end else begin
                    idx_nxt  = idx + 3'd1;
                    wrap_nxt = (idx == 3'd7);
                end
            end else if (!pp_dir) begin
                if (idx == 3'd7) begin
                    idx_nxt    = 3'd6;
                    pp_dir_nxt = 1'b1;
                    wrap_nxt   = 1'b1;
                end else begin
                    idx_nxt = idx + 3'd1;
                end
            end else begin
                if (idx == 3'd0) begin
                    idx_nxt    = 3'd1;
                    pp_dir_nxt = 1'b0;
                    wrap_nxt   = 1'b1;
                end else begin
                    idx_nxt = idx - 3'd1;
                end
            end
        end
    end

    assign bus.x    = idx[2];
    assign bus.y    = idx[1];
    assign bus.z    = idx[0];
    assign bus.tick = tick_r;
    assign bus.wrap = wrap_r;

`ifdef SCAN_WRAP_CNT_EN
    logic [7:0] wrap_cnt_r;

    always_ff @(posedge clk) begin
        if (!rst_n || bus.load)
            wrap_cnt_r <= '0;
        else if (wrap_nxt && wrap_cnt_r != 8'hff)
            wrap_cnt_r <= wrap_cnt_r + 8'd1;
    end

    assign bus.wrap_cnt = wrap_cnt_r;
`endif
endmodule

// File: tb/tb_scan_index_sequencer.sv
// Scoreboard bench for scan_index_sequencer: a behavioural model queues the expected post-edge
// outputs as each cycle's stimulus is driven; they are popped and compared once the edge has passed.
module tb_scan_index_sequencer;
    localparam int DWELL_W = 8;

    typedef struct packed {
        logic [2:0] idx;
        logic       tick;
        logic       wrap;
        logic [7:0] wc;
    } exp_t;

    logic clk;
    logic rst_n;
    scan_index_sequencer_if #(.DWELL_W(DWELL_W)) bus ();

    scan_index_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    int m_idx, m_cnt, m_wc;
    bit m_pp, m_idle, m_stepq, m_tick, m_wrap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        exp_t e;
        bit   adv;
        int   d;
        adv = 1'b0;
        if (!rst_n) begin
            m_idx = 0; m_cnt = 0; m_pp = 1'b0; m_idle = 1'b1;
            m_tick = 1'b0; m_wrap = 1'b0; m_wc = 0; m_stepq = 1'b0;
        end else begin
            m_tick = 1'b0;
            m_wrap = 1'b0;
            if (bus.load) begin
                m_idx = int'(bus.load_idx); m_cnt = 0; m_idle = 1'b1; m_wc = 0;
            end else if (bus.en) begin
                m_idle = 1'b0;
                if (m_cnt >= int'(bus.dwell)) begin adv = 1'b1; m_cnt = 0; end
                else m_cnt++;
            end else begin
                adv    = m_idle && bus.step && !m_stepq;
                m_idle = !adv;
                m_cnt  = 0;
            end
            if (!bus.load && !bus.mode) m_pp = bus.dir;
            if (adv) begin
                if (!bus.mode) begin
                    if (bus.dir) begin m_wrap = (m_idx == 0); m_idx = (m_idx + 7) % 8; end
                    else begin m_wrap = (m_idx == 7); m_idx = (m_idx + 1) % 8; end
                end else begin
                    d = m_pp ? -1 : 1;
                    if (m_idx + d > 7 || m_idx + d < 0) begin
                        m_wrap = 1'b1; m_pp = !m_pp; d = -d;
                    end
                    m_idx = m_idx + d;
                end
            end
            m_tick = adv;
            if (m_wrap && m_wc < 255) m_wc++;
            m_stepq = bus.step;
        end
        e.idx  = m_idx[2:0];
        e.tick = m_tick;
        e.wrap = m_wrap;
        e.wc   = m_wc[7:0];
        sb.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("idx",  {29'd0, bus.x, bus.y, bus.z}, {29'd0, e.idx});
        check("tick", {31'd0, bus.tick}, {31'd0, e.tick});
        check("wrap", {31'd0, bus.wrap}, {31'd0, e.wrap});
`ifdef SCAN_WRAP_CNT_EN
        check("wrap_cnt", {24'd0, bus.wrap_cnt}, {24'd0, e.wc});
`endif
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        logic [2:0] prev;
        rst_n = 1'b0;
        bus.en = 1'b0; bus.mode = 1'b0; bus.dir = 1'b0; bus.dwell = '0;
        bus.step = 1'b0; bus.load = 1'b0; bus.load_idx = '0;
        cycles(2);
        check("rst_xyz", {29'd0, bus.x, bus.y, bus.z}, 32'd0);

        // reset during RUN at idx=5
        rst_n = 1'b1;
        bus.load = 1'b1; bus.load_idx = 3'd5; cyc();
        bus.load = 1'b0; bus.en = 1'b1; bus.dwell = 8'd3; cycles(2);
        rst_n = 1'b0; cycles(2);
        check("rst_run_xyz", {29'd0, bus.x, bus.y, bus.z}, 32'd0);
        rst_n = 1'b1; bus.en = 1'b0;

        // linear up, dwell=2, from 6
        bus.dwell = 8'd2; bus.load = 1'b1; bus.load_idx = 3'd6; cyc();
        bus.load = 1'b0; bus.en = 1'b1; cycles(7);
        check("lin_up_end", {29'd0, bus.x, bus.y, bus.z}, 32'd0);

        // linear down, dwell=0, from 1
        bus.en = 1'b0; bus.dir = 1'b1; bus.dwell = 8'd0;
        bus.load = 1'b1; bus.load_idx = 3'd1; cyc();
        bus.load = 1'b0; bus.en = 1'b1; cycles(3);
        check("lin_dn_end", {29'd0, bus.x, bus.y, bus.z}, 32'd6);

        // ping-pong from 6 with pp_dir=up; endpoints never repeat
        bus.en = 1'b0; bus.dir = 1'b0; cyc();
        bus.load = 1'b1; bus.load_idx = 3'd6; cyc();
        bus.load = 1'b0; bus.mode = 1'b1; bus.en = 1'b1;
        prev = 3'd6;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (prev == 3'd7 || prev == 3'd0)
                check("pp_no_repeat", {31'd0, ({bus.x, bus.y, bus.z} == prev)}, 32'd0);
            prev = {bus.x, bus.y, bus.z};
        end

        // en drop mid-dwell, re-enable restarts the count
        bus.mode = 1'b0; bus.dwell = 8'd5; cycles(3);
        bus.en = 1'b0; cycles(2);
        bus.en = 1'b1; cycles(7);

        // step held high, then re-armed; load beats step
        bus.en = 1'b0; cyc();
        bus.step = 1'b1; cycles(4);
        bus.step = 1'b0; cycles(2);
        bus.step = 1'b1; cyc();
        bus.step = 1'b0; cyc();
        bus.step = 1'b1; bus.load = 1'b1; bus.load_idx = 3'd3; cyc();
        check("load_step_tick", {31'd0, bus.tick}, 32'd0);
        bus.step = 1'b0; bus.load = 1'b0; cyc();

        // dwell lowered 10 -> 2 with counter at 7
        bus.dwell = 8'd10; bus.en = 1'b1; cycles(7);
        bus.dwell = 8'd2; cyc();
        check("dwell_drop_tick", {31'd0, bus.tick}, 32'd1);

        // many wraps: saturates wrap_cnt when present
        bus.dwell = 8'd0; bus.dir = 1'b0; cycles(2410);
`ifdef SCAN_WRAP_CNT_EN
        check("wrap_cnt_sat", {24'd0, bus.wrap_cnt}, 32'd255);
        bus.load = 1'b1; bus.load_idx = 3'd2; cyc();
        check("wrap_cnt_load", {24'd0, bus.wrap_cnt}, 32'd0);
        bus.load = 1'b0;
`endif

        // random mix
        for (int i = 0; i < 600; i++) begin
            rst_n        = ($urandom_range(0, 49) != 0);
            bus.load     = ($urandom_range(0, 19) == 0);
            bus.load_idx = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) bus.en = ~bus.en;
            bus.mode     = ($urandom_range(0, 15) == 0) ? ~bus.mode : bus.mode;
            bus.dir      = ($urandom_range(0, 15) == 0) ? ~bus.dir : bus.dir;
            bus.dwell    = 8'($urandom_range(0, 3));
            bus.step     = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
